// File: rtl/i2c_counter_slave_mc.sv
// I2C slave owning NUM_CNT counters of CNT_W bits: write inc/dec/clear commands, read back the selected channel.
// Optional build macro I2C_CNT_SATURATE_EN: counters saturate instead of wrapping at the limits.
module i2c_counter_slave_mc #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         NUM_CNT     = 4,
  parameter int         CNT_W       = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i2c_scl,
  inout  wire                      i2c_sda,
  output logic [NUM_CNT*CNT_W-1:0] cnt_flat,
  output logic                     busy,
  output logic                     cmd_done
);

  localparam int CH_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

`ifdef I2C_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_CMD, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_prev_reg;
  logic                   sda_prev_reg;
  logic                   defer_fall_reg;
  logic                   defer_rise_reg;

  logic scl_s, sda_s, sda_in;
  logic scl_rise, scl_fall, scl_edge, scl_high;
  logic sda_fall_now, sda_rise_now;
  logic start_det, stop_det;

  assign sda_in = i2c_sda;
  assign scl_s  = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s  = sda_sync_reg[SYNC_STAGES-1];

  assign scl_rise     = scl_s & ~scl_prev_reg;
  assign scl_fall     = ~scl_s & scl_prev_reg;
  assign scl_edge     = scl_s ^ scl_prev_reg;
  assign scl_high     = scl_s & scl_prev_reg;
  assign sda_fall_now = ~sda_s & sda_prev_reg;
  assign sda_rise_now = sda_s & ~sda_prev_reg;

  // An SDA edge coinciding with an SCL edge is re-examined one clock later, once SCL has settled.
  assign start_det = scl_high & ((sda_fall_now) | (defer_fall_reg & ~sda_s));
  assign stop_det  = scl_high & ((sda_rise_now) | (defer_rise_reg & sda_s));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_reg   <= '1;
      sda_sync_reg   <= '1;
      scl_prev_reg   <= 1'b1;
      sda_prev_reg   <= 1'b1;
      defer_fall_reg <= 1'b0;
      defer_rise_reg <= 1'b0;
    end else begin
      scl_sync_reg   <= {scl_sync_reg[SYNC_STAGES-2:0], i2c_scl};
      sda_sync_reg   <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_prev_reg   <= scl_s;
      sda_prev_reg   <= sda_s;
      defer_fall_reg <= sda_fall_now & scl_edge;
      defer_rise_reg <= sda_rise_now & scl_edge;
    end
  end

  state_t            state_reg;
  logic [3:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic [6:0]        tx_reg;
  logic              ack_phase_reg;
  logic              rw_reg;
  logic              sda_oe_reg;
  logic              busy_reg;
  logic              cmd_done_reg;
  logic [1:0]        pend_op_reg;
  logic [CH_W-1:0]   pend_ch_reg;
  logic [CH_W-1:0]   sel_ch_reg;
  logic              exec_req_reg;
  logic [1:0]        exec_op_reg;
  logic [CH_W-1:0]   exec_ch_reg;

  logic [CNT_W-1:0]  cnt_arr [NUM_CNT];
  logic [CNT_W-1:0]  rd_val;
  logic [7:0]        rd_byte;
  logic              ch_ok;

  assign rd_val  = cnt_arr[sel_ch_reg];
  assign rd_byte = 8'(rd_val);
  assign ch_ok   = ({26'd0, shift_reg[5:0]} < NUM_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 8'd0;
      tx_reg        <= 7'd0;
      ack_phase_reg <= 1'b0;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      cmd_done_reg  <= 1'b0;
      pend_op_reg   <= OP_NOP;
      pend_ch_reg   <= '0;
      sel_ch_reg    <= '0;
      exec_req_reg  <= 1'b0;
      exec_op_reg   <= OP_NOP;
      exec_ch_reg   <= '0;
    end else begin
      cmd_done_reg <= exec_req_reg;
      exec_req_reg <= 1'b0;
      if (start_det || stop_det) begin
        // Hand the pending command to the execute stage; a nop never reaches it.
        if (pend_op_reg != OP_NOP) begin
          exec_req_reg <= 1'b1;
          exec_op_reg  <= pend_op_reg;
          exec_ch_reg  <= pend_ch_reg;
        end
        pend_op_reg   <= OP_NOP;
        sda_oe_reg    <= 1'b0;
        ack_phase_reg <= 1'b0;
        bit_cnt_reg   <= 4'd0;
        if (stop_det) begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end else begin
          state_reg <= S_ADDR;
        end
      end else begin
        case (state_reg)
          S_ADDR, S_WR_CMD: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_s};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == 4'd7)
                state_reg <= (state_reg == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_reg) begin
                if (shift_reg[7:1] == SLAVE_ADDR) begin
                  sda_oe_reg    <= 1'b1;
                  ack_phase_reg <= 1'b1;
                  busy_reg      <= 1'b1;
                  rw_reg        <= shift_reg[0];
                end else begin
                  state_reg <= S_IGNORE;
                end
              end else begin
                ack_phase_reg <= 1'b0;
                bit_cnt_reg   <= 4'd0;
                if (rw_reg) begin
                  tx_reg     <= rd_byte[6:0];
                  sda_oe_reg <= ~rd_byte[7];
                  state_reg  <= S_RD_DATA;
                end else begin
                  sda_oe_reg <= 1'b0;
                  state_reg  <= S_WR_CMD;
                end
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_reg) begin
                if (ch_ok) begin
                  sda_oe_reg    <= 1'b1;
                  ack_phase_reg <= 1'b1;
                  pend_op_reg   <= shift_reg[7:6];
                  pend_ch_reg   <= shift_reg[CH_W-1:0];
                  sel_ch_reg    <= shift_reg[CH_W-1:0];
                end else begin
                  state_reg <= S_IGNORE;
                end
              end else begin
                sda_oe_reg    <= 1'b0;
                ack_phase_reg <= 1'b0;
                bit_cnt_reg   <= 4'd0;
                state_reg     <= S_WR_CMD;
              end
            end
          end
          S_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_reg == 4'd8) begin
                sda_oe_reg    <= 1'b0;
                ack_phase_reg <= 1'b0;
                state_reg     <= S_RD_ACK;
              end else begin
                sda_oe_reg <= ~tx_reg[6];
                tx_reg     <= {tx_reg[5:0], 1'b0};
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) state_reg <= S_IGNORE;
              else       ack_phase_reg <= 1'b1;
            end else if (scl_fall && ack_phase_reg) begin
              ack_phase_reg <= 1'b0;
              bit_cnt_reg   <= 4'd0;
              tx_reg        <= rd_byte[6:0];
              sda_oe_reg    <= ~rd_byte[7];
              state_reg     <= S_RD_DATA;
            end
          end
          S_IDLE, S_IGNORE: ;
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_W-1:0] val_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          val_reg <= '0;
        end else if (exec_req_reg && exec_ch_reg == CH_W'(gi)) begin
          case (exec_op_reg)
            OP_INC:  if (!(SAT && (&val_reg)))       val_reg <= val_reg + 1'b1;
            OP_DEC:  if (!(SAT && (val_reg == '0)))  val_reg <= val_reg - 1'b1;
            OP_CLR:  val_reg <= '0;
            default: ;
          endcase
        end
      end
      assign cnt_arr[gi]                  = val_reg;
      assign cnt_flat[gi*CNT_W +: CNT_W]  = val_reg;
    end
  endgenerate

  assign i2c_sda  = sda_oe_reg ? 1'b0 : 1'bz;
  assign busy     = busy_reg;
  assign cmd_done = cmd_done_reg;

endmodule

// File: tb/tb_i2c_counter_slave_mc.sv
// Directed bench for i2c_counter_slave_mc: bit-banged I2C master with hand-computed counter values.
module tb_i2c_counter_slave_mc;
  localparam int Q = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_low = 1'b0;
  wire         sda;
  logic [31:0] cnt_flat;
  logic        busy;
  logic        cmd_done;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_counter_slave_mc dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i2c_scl  (scl),
    .i2c_sda  (sda),
    .cnt_flat (cnt_flat),
    .busy     (busy),
    .cmd_done (cmd_done)
  );

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  int busy_cnt = 0;

  always @(posedge clk) begin
    if (cmd_done) done_cnt++;
    if (busy) busy_cnt++;
    if (!m_low && sda === 1'b0) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; scl = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    m_low = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    m_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_low = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    ack = sda;
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    m_low = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_q();
      scl = 1'b1; wait_q();
      d = {d[6:0], sda};
      wait_q();
      scl = 1'b0;
    end
    wait_q();
    write_bit(nack);
  endtask

  logic        ack;
  logic [7:0]  rd;
  logic [31:0] exp_cnt;
  int          d0, l0, b0;

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cnt", cnt_flat, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, cmd_done}, 32'd0);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    reset_n = 1'b1;
    wait_q();

    // 1: inc ch2
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h84, ack); chk("t1_addr_ack", {31'd0, ack}, 32'd0);
    chk("t1_busy_hi", {31'd0, busy}, 32'd1);
    write_byte(8'h42, ack); chk("t1_cmd_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    exp_cnt = 32'h0001_0000;
    chk("t1_cnt", cnt_flat, exp_cnt);
    chk("t1_done", done_cnt - d0, 32'd1);
    chk("t1_busy_lo", {31'd0, busy}, 32'd0);
    $display("txn 1: write 0x84 0x42 cnt=0x%08h", cnt_flat);

    // 2: foreign address
    d0 = done_cnt; l0 = low_cnt; b0 = busy_cnt;
    i2c_start();
    write_byte(8'h86, ack); chk("t2_addr_nack", {31'd0, ack}, 32'd1);
    write_byte(8'h42, ack); chk("t2_cmd_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("t2_cnt", cnt_flat, exp_cnt);
    chk("t2_sda_never", low_cnt - l0, 32'd0);
    chk("t2_busy_never", busy_cnt - b0, 32'd0);
    chk("t2_done", done_cnt - d0, 32'd0);
    $display("txn 2: write 0x86 0x42 cnt=0x%08h", cnt_flat);

    // 3: dec ch1 at 0
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h84, ack); chk("t3_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h81, ack); chk("t3_cmd_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
`ifdef I2C_CNT_SATURATE_EN
    exp_cnt = 32'h0001_0000;
`else
    exp_cnt = 32'h0001_FF00;
`endif
    chk("t3_cnt", cnt_flat, exp_cnt);
    chk("t3_done", done_cnt - d0, 32'd1);
    $display("txn 3: write 0x84 0x81 cnt=0x%08h", cnt_flat);

    // two commands in one write: last (inc ch3) wins over dec ch3
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h84, ack); chk("tm_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h83, ack); chk("tm_cmd1_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h43, ack); chk("tm_cmd2_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    exp_cnt = exp_cnt + 32'h0100_0000;
    chk("tm_cnt", cnt_flat, exp_cnt);
    chk("tm_done", done_cnt - d0, 32'd1);
    $display("txn m: write 0x84 0x83 0x43 cnt=0x%08h", cnt_flat);

    // 4: inc then nop (nop wins), Sr, read ch3 twice
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h84, ack); chk("t4_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h43, ack); chk("t4_inc_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h03, ack); chk("t4_nop_ack", {31'd0, ack}, 32'd0);
    i2c_rstart();
    chk("t4_busy_sr", {31'd0, busy}, 32'd1);
    write_byte(8'h85, ack); chk("t4_rd_addr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b0, rd); chk("t4_rd_first", {24'd0, rd}, 32'h01);
    read_byte(1'b1, rd); chk("t4_rd_again", {24'd0, rd}, 32'h01);
    chk("t4_sda_release", {31'd0, sda}, 32'd1);
    i2c_stop();
    chk("t4_cnt", cnt_flat, exp_cnt);
    chk("t4_done", done_cnt - d0, 32'd0);
    chk("t4_busy_lo", {31'd0, busy}, 32'd0);
    $display("txn 4: write 0x84 0x43 0x03 Sr read 0x85 -> 0x%02h", rd);

    // 5: channel out of range
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h84, ack); chk("t5_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'h45, ack); chk("t5_cmd_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("t5_cnt", cnt_flat, exp_cnt);
    chk("t5_done", done_cnt - d0, 32'd0);
    $display("txn 5: write 0x84 0x45 cnt=0x%08h", cnt_flat);

    // 6: reset after the 4th command bit
    i2c_start();
    write_byte(8'h84, ack); chk("t6_addr_ack", {31'd0, ack}, 32'd0);
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
    reset_n = 1'b0;
    m_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_rst_sda", {31'd0, sda}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_cnt", cnt_flat, 32'h0);
    reset_n = 1'b1;
    scl = 1'b1;
    wait_q();
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h84, ack); chk("t6_addr_ack2", {31'd0, ack}, 32'd0);
    write_byte(8'h40, ack); chk("t6_cmd_ack2", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("t6_cnt", cnt_flat, 32'h0000_0001);
    chk("t6_done", done_cnt - d0, 32'd1);
    $display("txn 6: reset mid-write, then write 0x84 0x40 cnt=0x%08h", cnt_flat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
